io_pad_bank: RTL and testbench
==============================

IO_PAD_BANK -- requirements
Module: io_pad_bank

Interface
REQ-001 Parameter NUM_PADS, default 16, number of bidirectional pad channels (1..32).
REQ-002 Parameter SYNC_STAGES, default 2, input synchroniser depth (>=2).
REQ-003 Parameter DEBOUNCE_CYCLES, default 4, consecutive stable cycles required before a filtered input changes (1..255).
REQ-004 HCLK  input  1  sole clock, all state on rising edge.
REQ-005 HRESET  input  1  synchronous, active-high reset.
REQ-006 wr_en  input  1  register write strobe, single cycle.
REQ-007 rd_en  input  1  register read strobe, single cycle.
REQ-008 addr  input  3  register index.
REQ-009 wdata  input  NUM_PADS  write data.
REQ-010 rdata  output  NUM_PADS  read data, registered.
REQ-011 pad_in  input  NUM_PADS  raw asynchronous pad input.
REQ-012 pad_out  output  NUM_PADS  pad output value.
REQ-013 pad_oe  output  NUM_PADS  pad output enable, 1 = drive.
REQ-014 pad_pu / pad_pd  output  NUM_PADS each  pull-up / pull-down enables.
REQ-015 irq  output  1  level interrupt, OR of enabled pending bits.

Function
REQ-016 Register map: 0 DATAIN (RO, filtered input), 1 OUT, 2 DIR (1 = output), 3 PU, 4 PD, 5 IRQ_EN, 6 IRQ_POL (1 = rising, 0 = falling), 7 IRQ_STATUS (W1C).
REQ-017 Writes take effect on the edge wr_en is sampled; writes to DATAIN are ignored.
REQ-018 rdata is updated on the edge rd_en is sampled (1-cycle latency) and holds its value otherwise.
REQ-019 pad_out = OUT, pad_oe = DIR, pad_pu = PU, pad_pd = PD & ~PU (pull-up wins when both set).
REQ-020 Each pad_in bit passes through SYNC_STAGES flops before any other use.
REQ-021 Filtered value updates per REQ-030/031; previous filtered value is registered for edge detection.
REQ-022 A rising (falling) edge of filtered bit i with IRQ_POL[i]=1 (0) sets IRQ_STATUS[i] on the next edge, independent of IRQ_EN.
REQ-023 irq = |(IRQ_STATUS & IRQ_EN), combinational from registers.
REQ-024 Writing 1 to IRQ_STATUS[i] clears it; writing 0 has no effect.
REQ-025 Simultaneous set event and W1C on the same bit: set wins, bit remains 1.
REQ-026 Changing IRQ_POL does not itself generate an event; only filtered edges do.
REQ-027 wr_en and rd_en in the same cycle to the same address: rdata returns the pre-write value.
REQ-028 Read of DIR/OUT/PU/PD/IRQ_EN/IRQ_POL returns stored value; IRQ_STATUS read does not clear.

Reset
REQ-029 While HRESET=1 at a rising edge: all registers, synchroniser flops, filters, debounce counters, rdata cleared to 0; hence pad_oe=0, pad_out=0, pad_pu=0, pad_pd=0, irq=0; reset mid-debounce discards the count; no edge event is generated on reset release.

Configuration
REQ-030 With IO_BANK_DEBOUNCE_EN defined: per-pad counter increments while synchronised value differs from filtered value, clears when equal; filtered value takes synchronised value and counter clears when count reaches DEBOUNCE_CYCLES-1 and mismatch persists (i.e. after DEBOUNCE_CYCLES consecutive mismatch cycles).
REQ-031 Without IO_BANK_DEBOUNCE_EN: no counters are synthesised; filtered value = last synchroniser stage, DEBOUNCE_CYCLES unused.

Verification
REQ-032 Reset: HRESET high 3 cycles with pad_in=16'hFFFF -> all pad outputs 0, irq 0, read DATAIN after release+SYNC_STAGES cycles returns 16'hFFFF with IRQ_STATUS=0.
REQ-033 Config: write DIR=16'h00FF, OUT=16'h00A5, PU=16'h0F0F, PD=16'h0FF0 -> pad_oe=16'h00FF, pad_out=16'h00A5, pad_pu=16'h0F0F, pad_pd=16'h00F0.
REQ-034 Rising IRQ (debounce off): IRQ_EN[3]=1, IRQ_POL[3]=1, pad_in[3] 0->1 -> IRQ_STATUS[3]=1 and irq=1 exactly SYNC_STAGES+1 edges later; pad_in[3] 1->0 gives no new event.
REQ-035 Debounce (on, DEBOUNCE_CYCLES=4): pad_in[0] high 3 cycles then low -> DATAIN[0] stays 0; high 4+ cycles -> DATAIN[0]=1 after SYNC_STAGES+4 edges.
REQ-036 W1C race: write IRQ_STATUS=16'h0001 in the cycle a bit-0 event is set -> bit 0 reads 1; subsequent write 16'h0001 -> reads 0, irq=0.
REQ-037 Masking: event on pad 5 with IRQ_EN[5]=0 -> IRQ_STATUS[5]=1, irq=0; then write IRQ_EN=16'h0020 -> irq=1 same cycle after write edge.

Source files
------------

// File: rtl/io_pad_bank.sv
// io_pad_bank: register-mapped bank of bidirectional pad channels with input synchronisers,
// edge interrupts and optional per-pad debounce (enabled by defining IO_BANK_DEBOUNCE_EN).
module io_pad_bank #(
  parameter int NUM_PADS        = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic                wr_en,
  input  logic                rd_en,
  input  logic [2:0]          addr,
  input  logic [NUM_PADS-1:0] wdata,
  output logic [NUM_PADS-1:0] rdata,
  input  logic [NUM_PADS-1:0] pad_in,
  output logic [NUM_PADS-1:0] pad_out,
  output logic [NUM_PADS-1:0] pad_oe,
  output logic [NUM_PADS-1:0] pad_pu,
  output logic [NUM_PADS-1:0] pad_pd,
  output logic                irq
);

  localparam logic [2:0] ADDR_DATAIN  = 3'd0;
  localparam logic [2:0] ADDR_OUT     = 3'd1;
  localparam logic [2:0] ADDR_DIR     = 3'd2;
  localparam logic [2:0] ADDR_PU      = 3'd3;
  localparam logic [2:0] ADDR_PD      = 3'd4;
  localparam logic [2:0] ADDR_IRQ_EN  = 3'd5;
  localparam logic [2:0] ADDR_IRQ_POL = 3'd6;
  localparam logic [2:0] ADDR_IRQ_ST  = 3'd7;

  if (NUM_PADS < 1 || NUM_PADS > 32) begin : g_bad_num_pads
    $error("io_pad_bank: NUM_PADS must be 1..32");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("io_pad_bank: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
    $error("io_pad_bank: DEBOUNCE_CYCLES must be 1..255");
  end

  logic [NUM_PADS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_PADS-1:0] sync_in;
  logic [NUM_PADS-1:0] filt;
  logic [NUM_PADS-1:0] filt_prev;
  logic [NUM_PADS-1:0] edge_evt;
  logic [NUM_PADS-1:0] w1c_mask;
  logic [NUM_PADS-1:0] rd_mux;

  logic [NUM_PADS-1:0] out_q;
  logic [NUM_PADS-1:0] dir_q;
  logic [NUM_PADS-1:0] pu_q;
  logic [NUM_PADS-1:0] pd_q;
  logic [NUM_PADS-1:0] irq_en_q;
  logic [NUM_PADS-1:0] irq_pol_q;
  logic [NUM_PADS-1:0] irq_st_q;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= pad_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync_in = sync_q[SYNC_STAGES-1];

`ifdef IO_BANK_DEBOUNCE_EN
  // A pad's filtered value flips only after DEBOUNCE_CYCLES consecutive mismatching samples.
  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [7:0] db_cnt [NUM_PADS];

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      filt <= '0;
      for (int i = 0; i < NUM_PADS; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PADS; i++) begin
        if (sync_in[i] == filt[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          filt[i]   <= sync_in[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 8'd1;
        end
      end
    end
  end
`else
  assign filt = sync_in;
`endif

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      filt_prev <= '0;
    end else begin
      filt_prev <= filt;
    end
  end

  // Polarity only selects which filtered edge counts, so rewriting it never raises an event.
  assign edge_evt = (filt & ~filt_prev & irq_pol_q) | (~filt & filt_prev & ~irq_pol_q);
  assign w1c_mask = (wr_en && addr == ADDR_IRQ_ST) ? wdata : '0;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      out_q     <= '0;
      dir_q     <= '0;
      pu_q      <= '0;
      pd_q      <= '0;
      irq_en_q  <= '0;
      irq_pol_q <= '0;
      irq_st_q  <= '0;
    end else begin
      if (wr_en) begin
        case (addr)
          ADDR_OUT:     out_q     <= wdata;
          ADDR_DIR:     dir_q     <= wdata;
          ADDR_PU:      pu_q      <= wdata;
          ADDR_PD:      pd_q      <= wdata;
          ADDR_IRQ_EN:  irq_en_q  <= wdata;
          ADDR_IRQ_POL: irq_pol_q <= wdata;
          default:      ;
        endcase
      end
      irq_st_q <= (irq_st_q & ~w1c_mask) | edge_evt;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_DATAIN:  rd_mux = filt;
      ADDR_OUT:     rd_mux = out_q;
      ADDR_DIR:     rd_mux = dir_q;
      ADDR_PU:      rd_mux = pu_q;
      ADDR_PD:      rd_mux = pd_q;
      ADDR_IRQ_EN:  rd_mux = irq_en_q;
      ADDR_IRQ_POL: rd_mux = irq_pol_q;
      ADDR_IRQ_ST:  rd_mux = irq_st_q;
      default:      rd_mux = '0;
    endcase
  end

  // Read data comes from the pre-edge register values, so a same-cycle write is not visible.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= rd_mux;
    end
  end

  assign pad_out = out_q;
  assign pad_oe  = dir_q;
  assign pad_pu  = pu_q;
  assign pad_pd  = pd_q & ~pu_q;
  assign irq     = |(irq_st_q & irq_en_q);

endmodule

// File: tb/tb_io_pad_bank.sv
// tb_io_pad_bank: directed scenarios plus randomized traffic checked every cycle against a
// delay-line/window reference model of io_pad_bank (debounce model follows IO_BANK_DEBOUNCE_EN).
module tb_io_pad_bank;

  localparam int NP   = 16;
  localparam int SS   = 2;
  localparam int DB   = 4;
  localparam int HIST = SS + DB + 1;
`ifdef IO_BANK_DEBOUNCE_EN
  localparam int LAT = SS + DB + 1;
`else
  localparam int LAT = SS + 1;
`endif

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic          wr_en;
  logic          rd_en;
  logic [2:0]    addr;
  logic [NP-1:0] wdata;
  logic [NP-1:0] rdata;
  logic [NP-1:0] pad_in;
  logic [NP-1:0] pad_out;
  logic [NP-1:0] pad_oe;
  logic [NP-1:0] pad_pu;
  logic [NP-1:0] pad_pd;
  logic          irq;

  io_pad_bank #(.NUM_PADS(NP), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .wdata(wdata), .rdata(rdata), .pad_in(pad_in), .pad_out(pad_out), .pad_oe(pad_oe),
    .pad_pu(pad_pu), .pad_pd(pad_pd), .irq(irq)
  );

  always #5 HCLK = ~HCLK;

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  task automatic checkOutput(input string tag, input logic [NP-1:0] got, input logic [NP-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference state; hist[k] is the pad_in value sampled k edges ago.
  logic [NP-1:0] m_out, m_dir, m_pu, m_pd, m_en, m_pol, m_stat, m_rdata, m_filt, m_prev;
  logic [NP-1:0] hist [HIST];

  function automatic logic [NP-1:0] readModel(input logic [2:0] a);
    case (a)
      3'd0:    return m_filt;
      3'd1:    return m_out;
      3'd2:    return m_dir;
      3'd3:    return m_pu;
      3'd4:    return m_pd;
      3'd5:    return m_en;
      3'd6:    return m_pol;
      default: return m_stat;
    endcase
  endfunction

  always @(posedge HCLK) begin : model
    logic [NP-1:0] ev;
    bit            all_diff;
    if (HRESET) begin
      {m_out, m_dir, m_pu, m_pd, m_en, m_pol, m_stat, m_rdata, m_filt, m_prev} = '0;
      for (int k = 0; k < HIST; k++) hist[k] = '0;
    end else begin
      ev = (m_filt & ~m_prev & m_pol) | (~m_filt & m_prev & ~m_pol);
      if (rd_en) m_rdata = readModel(addr);
      if (wr_en) begin
        case (addr)
          3'd1:    m_out  = wdata;
          3'd2:    m_dir  = wdata;
          3'd3:    m_pu   = wdata;
          3'd4:    m_pd   = wdata;
          3'd5:    m_en   = wdata;
          3'd6:    m_pol  = wdata;
          3'd7:    m_stat = m_stat & ~wdata;
          default: ;
        endcase
      end
      m_stat = m_stat | ev;
      m_prev = m_filt;
      for (int k = HIST - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = pad_in;
`ifdef IO_BANK_DEBOUNCE_EN
      for (int i = 0; i < NP; i++) begin
        all_diff = 1'b1;
        for (int k = SS; k < SS + DB; k++) if (hist[k][i] == m_filt[i]) all_diff = 1'b0;
        if (all_diff) m_filt[i] = ~m_filt[i];
      end
`else
      all_diff = 1'b0;
      m_filt = hist[SS-1];
`endif
    end
  end

  always @(negedge HCLK) begin
    if (check_en) begin
      checkOutput("pad_out", pad_out, m_out);
      checkOutput("pad_oe", pad_oe, m_dir);
      checkOutput("pad_pu", pad_pu, m_pu);
      checkOutput("pad_pd", pad_pd, m_pd & ~m_pu);
      checkOutput("rdata", rdata, m_rdata);
      checkOutput("irq", NP'(irq), NP'(|(m_stat & m_en)));
    end
  end

  task automatic tick();
    @(negedge HCLK);
  endtask

  task automatic writeReg(input logic [2:0] a, input logic [NP-1:0] d);
    wr_en = 1'b1; addr = a; wdata = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic readReg(input logic [2:0] a);
    rd_en = 1'b1; addr = a;
    tick();
    rd_en = 1'b0;
  endtask

  // One random bus cycle with sparse pad toggles and an occasional reset.
  task automatic applyStimulus();
    HRESET = ($urandom_range(0, 199) == 0);
    wr_en  = ($urandom_range(0, 3) == 0);
    rd_en  = ($urandom_range(0, 2) == 0);
    addr   = 3'($urandom_range(0, 7));
    wdata  = NP'($urandom);
    if ($urandom_range(0, 2) == 0) pad_in = pad_in ^ NP'($urandom & $urandom & $urandom);
    tick();
  endtask

  initial begin
    HRESET = 1'b1; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;
    pad_in = 16'hFFFF;
    tick();
    check_en = 1'b1;
    repeat (2) tick();
    checkOutput("reset_pad_oe", pad_oe, 16'h0000);
    checkOutput("reset_pad_out", pad_out, 16'h0000);
    checkOutput("reset_pad_pu_pd", pad_pu | pad_pd, 16'h0000);
    checkOutput("reset_irq", NP'(irq), 16'h0000);
    HRESET = 1'b0;
    repeat (SS + DB + 1) tick();
    readReg(3'd0);
    checkOutput("datain_after_reset", rdata, 16'hFFFF);
    readReg(3'd7);
    checkOutput("status_after_reset", rdata, 16'h0000);

    writeReg(3'd2, 16'h00FF);
    writeReg(3'd1, 16'h00A5);
    writeReg(3'd3, 16'h0F0F);
    writeReg(3'd4, 16'h0FF0);
    checkOutput("cfg_pad_oe", pad_oe, 16'h00FF);
    checkOutput("cfg_pad_out", pad_out, 16'h00A5);
    checkOutput("cfg_pad_pu", pad_pu, 16'h0F0F);
    checkOutput("cfg_pad_pd", pad_pd, 16'h00F0);
    readReg(3'd4);
    checkOutput("cfg_read_pd", rdata, 16'h0FF0);

    // Falling edges (default polarity) on every pad, then clear them all.
    pad_in = 16'h0000;
    repeat (LAT + 2) tick();
    readReg(3'd7);
    checkOutput("fall_all_status", rdata, 16'hFFFF);
    writeReg(3'd7, 16'hFFFF);
    writeReg(3'd6, 16'h0008);
    writeReg(3'd5, 16'h0008);
    checkOutput("irq_idle", NP'(irq), 16'h0000);

    pad_in = 16'h0008;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      checkOutput($sformatf("rise3_irq_edge%0d", k), NP'(irq), (k == LAT) ? 16'h0001 : 16'h0000);
    end
    readReg(3'd7);
    checkOutput("rise3_status", rdata, 16'h0008);
    pad_in = 16'h0000;
    repeat (LAT + 2) tick();
    readReg(3'd7);
    checkOutput("fall3_no_event", rdata, 16'h0008);
    writeReg(3'd7, 16'h0008);
    checkOutput("rise3_cleared_irq", NP'(irq), 16'h0000);

    // Clear lands on the same edge the bit-0 event is set.
    writeReg(3'd6, 16'h0009);
    writeReg(3'd5, 16'h0009);
    pad_in = 16'h0001;
    repeat (LAT - 1) tick();
    writeReg(3'd7, 16'h0001);
    readReg(3'd7);
    checkOutput("w1c_race_status", rdata, 16'h0001);
    checkOutput("w1c_race_irq", NP'(irq), 16'h0001);
    writeReg(3'd7, 16'h0001);
    readReg(3'd7);
    checkOutput("w1c_clear_status", rdata, 16'h0000);
    checkOutput("w1c_clear_irq", NP'(irq), 16'h0000);

    writeReg(3'd6, 16'h0029);
    pad_in = 16'h0021;
    repeat (LAT + 1) tick();
    readReg(3'd7);
    checkOutput("mask_status", rdata, 16'h0020);
    checkOutput("mask_irq_off", NP'(irq), 16'h0000);
    writeReg(3'd5, 16'h0020);
    checkOutput("mask_irq_on", NP'(irq), 16'h0001);
    writeReg(3'd7, 16'hFFFF);

`ifdef IO_BANK_DEBOUNCE_EN
    pad_in = 16'h0020;
    repeat (LAT + 2) tick();
    pad_in = 16'h0021;
    repeat (DB - 1) tick();
    pad_in = 16'h0020;
    repeat (LAT + 2) tick();
    readReg(3'd0);
    checkOutput("debounce_glitch", rdata, 16'h0020);
    pad_in = 16'h0021;
    repeat (SS + DB - 1) tick();
    readReg(3'd0);
    checkOutput("debounce_one_early", rdata, 16'h0020);
    readReg(3'd0);
    checkOutput("debounce_settled", rdata, 16'h0021);
`endif

    // Same-cycle read and write of one register returns the old contents.
    wr_en = 1'b1; rd_en = 1'b1; addr = 3'd1; wdata = 16'h1234;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    checkOutput("rd_wr_same_addr", rdata, 16'h00A5);

    repeat (1500) applyStimulus();
    HRESET = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
